// File: rtl/memory_control_ws.sv
// memory_control_ws: LC-3 MAR/MDR memory interface with wait-state ready FSM and keyboard/display MMIO.
module memory_control_ws #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 64,
  parameter int WAIT_STATES = 2,
  parameter logic [DATA_W-1:0] KBSR_ADDR = 16'hFE00,
  parameter logic [DATA_W-1:0] KBDR_ADDR = 16'hFE02,
  parameter logic [DATA_W-1:0] DSR_ADDR = 16'hFE04,
  parameter logic [DATA_W-1:0] DDR_ADDR = 16'hFE06
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  input  logic              i_LD_MDR,
  input  logic              i_LD_MAR,
  input  logic              i_RW,
  input  logic              i_MIO_EN,
  input  logic [DATA_W-1:0] i_Bus,
  output logic [DATA_W-1:0] o_Bus,
  output logic              o_Ready_Bit,
  input  logic              i_KB_Valid,
  input  logic [7:0]        i_KB_Data,
  input  logic              i_Disp_Busy,
  output logic              o_Disp_Valid,
  output logic [7:0]        o_Disp_Data
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t state_q;
  logic [DATA_W-1:0] mar_q, mdr_q, rd_q, addr_q, wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [3:0] cnt_q;
  logic [7:0] kb_data_q;
  logic rw_q, kb_flag_q;
  logic req_ram, commit, c_rw, c_ram, kb_set, kb_clr;
  logic [DATA_W-1:0] c_addr, c_wdata, c_rdata;

  function automatic logic is_mmio(input logic [DATA_W-1:0] a);
    return a == KBSR_ADDR || a == KBDR_ADDR || a == DSR_ADDR || a == DDR_ADDR;
  endfunction

  assign o_Bus = mdr_q;
  assign req_ram = !is_mmio(mar_q) && mar_q < DATA_W'(DEPTH);
  // Zero-wait accesses commit on the request edge, so they use live MAR/MDR.
  assign commit = (state_q == S_IDLE && i_MIO_EN && (!req_ram || WAIT_STATES == 0)) ||
                  (state_q == S_WAIT && i_MIO_EN && cnt_q == 4'd1);
  assign c_addr = state_q == S_IDLE ? mar_q : addr_q;
  assign c_wdata = state_q == S_IDLE ? mdr_q : wdata_q;
  assign c_rw = state_q == S_IDLE ? i_RW : rw_q;
  assign c_ram = !is_mmio(c_addr) && c_addr < DATA_W'(DEPTH);
  assign c_rdata = c_addr == KBSR_ADDR ? {kb_flag_q, {(DATA_W-1){1'b0}}} :
                   c_addr == KBDR_ADDR ? {{(DATA_W-8){1'b0}}, kb_data_q} :
                   c_addr == DSR_ADDR  ? {~i_Disp_Busy & ~o_Disp_Valid, {(DATA_W-1){1'b0}}} :
                   c_ram ? mem[c_addr[AW-1:0]] : '0;
  assign kb_set = i_KB_Valid && !kb_flag_q;
  assign kb_clr = commit && !c_rw && c_addr == KBDR_ADDR;

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_q <= S_IDLE;
      mar_q <= '0;
      mdr_q <= '0;
      rd_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rw_q <= 1'b0;
      cnt_q <= '0;
      kb_flag_q <= 1'b0;
      kb_data_q <= '0;
      o_Ready_Bit <= 1'b0;
      o_Disp_Valid <= 1'b0;
      o_Disp_Data <= '0;
    end else begin
      if (i_LD_MAR) mar_q <= i_Bus;
      if (i_LD_MDR) mdr_q <= i_MIO_EN ? rd_q : i_Bus;
      case (state_q)
        S_IDLE: if (i_MIO_EN) begin
          addr_q <= mar_q;
          wdata_q <= mdr_q;
          rw_q <= i_RW;
          cnt_q <= 4'(WAIT_STATES);
          state_q <= req_ram && WAIT_STATES != 0 ? S_WAIT : S_DONE;
        end
        S_WAIT: begin
          cnt_q <= cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
          state_q <= !i_MIO_EN ? S_IDLE : cnt_q == 4'd1 ? S_DONE : S_WAIT;
        end
        default: state_q <= S_IDLE;
      endcase
      o_Ready_Bit <= commit;
      if (commit && !c_rw) rd_q <= c_rdata;
      // A char arriving while the flag is set is lost even if KBDR is read this edge.
      kb_flag_q <= kb_set || (kb_flag_q && !kb_clr);
      if (kb_set) kb_data_q <= i_KB_Data;
      o_Disp_Valid <= state_q == S_DONE && rw_q && addr_q == DDR_ADDR;
      if (state_q == S_DONE && rw_q && addr_q == DDR_ADDR) o_Disp_Data <= wdata_q[7:0];
    end
  end

  always_ff @(posedge i_CLK)
    if (i_RST_N && commit && c_rw && c_ram) mem[c_addr[AW-1:0]] <= c_wdata;
endmodule

// File: tb/tb_memory_control_ws.sv
// tb_memory_control_ws: vector table, hand-written corner sequences and a transaction-level random model.
module tb_memory_control_ws;
  logic clk = 0, rst_n, ld_mdr, ld_mar, rw, mio, kb_valid, disp_busy;
  logic [15:0] bus, obus;
  logic [7:0] kb_data, disp_data;
  logic ready, disp_valid;
  int checks = 0, errors = 0, disp_cnt = 0;
  logic [7:0] last_disp = 0;

  memory_control_ws dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_LD_MDR(ld_mdr), .i_LD_MAR(ld_mar), .i_RW(rw),
    .i_MIO_EN(mio), .i_Bus(bus), .o_Bus(obus), .o_Ready_Bit(ready), .i_KB_Valid(kb_valid),
    .i_KB_Data(kb_data), .i_Disp_Busy(disp_busy), .o_Disp_Valid(disp_valid), .o_Disp_Data(disp_data));

  always #5 clk = ~clk;

  always @(negedge clk) if (disp_valid) begin
    disp_cnt++;
    last_disp = disp_data;
  end

  typedef struct {
    logic rw;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] exp;
    int lat;
  } vec_t;

  logic [15:0] mem_m [64];
  logic kb_full;
  logic [7:0] kb_char;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output int lat);
    @(negedge clk); ld_mar = 1; bus = a;
    @(negedge clk); ld_mar = 0; ld_mdr = 1; mio = 0; bus = d;
    @(negedge clk); ld_mdr = 0; rw = w; mio = 1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ready) begin
        lat = n;
        break;
      end
    end
    ld_mdr = 1;
    @(negedge clk); ld_mdr = 0; mio = 0;
    rd = obus;
    chk("r_pulse", {31'b0, ready}, 0);
  endtask

  task automatic kb_pulse(input logic [7:0] c);
    @(negedge clk); kb_valid = 1; kb_data = c;
    @(negedge clk); kb_valid = 0;
  endtask

  function automatic int m_lat(input logic [15:0] a);
    return (a == 16'hFE00 || a == 16'hFE02 || a == 16'hFE04 || a == 16'hFE06 || a >= 64) ? 1 : 3;
  endfunction

  vec_t tv [15];
  logic [15:0] rd, exp, a, d;
  int lat, seen, c0, m_disp_cnt;
  logic [7:0] m_last_disp;
  logic w;

  initial begin
    rst_n = 0; ld_mdr = 0; ld_mar = 0; rw = 0; mio = 0; kb_valid = 0; disp_busy = 0;
    bus = 0; kb_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 0);
    chk("rst_bus", {16'b0, obus}, 0);
    chk("rst_dvalid", {31'b0, disp_valid}, 0);
    chk("rst_ddata", {24'b0, disp_data}, 0);
    rst_n = 1;

    tv = '{'{1'b1, 16'h0000, 16'h1111, 16'h0000, 3},
           '{1'b1, 16'h0005, 16'hBEEF, 16'h0000, 3},
           '{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 3},
           '{1'b1, 16'h003F, 16'hA5A5, 16'h0000, 3},
           '{1'b0, 16'h003F, 16'h0000, 16'hA5A5, 3},
           '{1'b1, 16'h0040, 16'h1234, 16'h0000, 1},
           '{1'b0, 16'h0040, 16'h0000, 16'h0000, 1},
           '{1'b0, 16'h0000, 16'h0000, 16'h1111, 3},
           '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1},
           '{1'b0, 16'hFE04, 16'h0000, 16'h8000, 1},
           '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 1},
           '{1'b1, 16'hFE00, 16'hFFFF, 16'h0000, 1},
           '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 1},
           '{1'b0, 16'hFE06, 16'h0000, 16'h0000, 1},
           '{1'b0, 16'hFE01, 16'h0000, 16'h0000, 1}};
    for (int i = 0; i < 15; i++) begin
      access(tv[i].rw, tv[i].addr, tv[i].wd, rd, lat);
      chk($sformatf("tv%0d_lat", i), 32'(lat), 32'(tv[i].lat));
      if (!tv[i].rw) chk($sformatf("tv%0d_data", i), {16'b0, rd}, {16'b0, tv[i].exp});
    end

    // Abort: drop request during the wait of a write.
    access(1, 3, 16'h7777, rd, lat);
    @(negedge clk); ld_mar = 1; bus = 3;
    @(negedge clk); ld_mar = 0; ld_mdr = 1; bus = 16'hDEAD;
    @(negedge clk); ld_mdr = 0; rw = 1; mio = 1;
    @(negedge clk); mio = 0;
    seen = 0;
    repeat (5) @(negedge clk) if (ready) seen++;
    chk("abort_no_r", 32'(seen), 0);
    access(0, 3, 0, rd, lat);
    chk("abort_lat", 32'(lat), 3);
    chk("abort_ram", {16'b0, rd}, 32'h7777);

    // Reset held mid-wait with the request still asserted.
    access(1, 4, 16'h1357, rd, lat);
    @(negedge clk); ld_mar = 1; bus = 4;
    @(negedge clk); ld_mar = 0; ld_mdr = 1; bus = 16'h2468;
    @(negedge clk); ld_mdr = 0; rw = 1; mio = 1;
    @(negedge clk); rst_n = 0;
    repeat (3) begin
      @(negedge clk);
      chk("mrst_ready", {31'b0, ready}, 0);
      chk("mrst_bus", {16'b0, obus}, 0);
      chk("mrst_disp", {23'b0, disp_valid, disp_data}, 0);
    end
    rst_n = 1; mio = 0;
    access(0, 4, 0, rd, lat);
    chk("mrst_ram", {16'b0, rd}, 32'h1357);

    // Keyboard
    kb_pulse(8'h41);
    access(0, 16'hFE00, 0, rd, lat); chk("kbsr_full", {16'b0, rd}, 32'h8000);
    kb_pulse(8'h42);
    access(0, 16'hFE02, 0, rd, lat); chk("kbdr_first", {16'b0, rd}, 32'h0041);
    access(0, 16'hFE00, 0, rd, lat); chk("kbsr_empty", {16'b0, rd}, 32'h0000);
    kb_pulse(8'h43);
    access(0, 16'hFE02, 0, rd, lat); chk("kbdr_next", {16'b0, rd}, 32'h0043);

    // Display
    c0 = disp_cnt;
    access(1, 16'hFE06, 16'h0058, rd, lat);
    chk("ddr_lat", 32'(lat), 1);
    chk("ddr_valid", {31'b0, disp_valid}, 1);
    chk("ddr_data", {24'b0, disp_data}, 32'h58);
    @(negedge clk);
    chk("ddr_valid_drop", {31'b0, disp_valid}, 0);
    chk("ddr_count", 32'(disp_cnt - c0), 1);
    disp_busy = 1;
    access(0, 16'hFE04, 0, rd, lat); chk("dsr_busy", {16'b0, rd}, 0);
    disp_busy = 0;
    access(0, 16'hFE04, 0, rd, lat); chk("dsr_ready", {16'b0, rd}, 32'h8000);

    // Random against a transaction-level model.
    access(0, 16'hFE02, 0, rd, lat);
    kb_full = 0; kb_char = 8'h43;
    for (int i = 0; i < 64; i++) begin
      mem_m[i] = 16'($urandom);
      access(1, 16'(i), mem_m[i], rd, lat);
    end
    m_disp_cnt = disp_cnt; m_last_disp = last_disp;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        d = 16'($urandom);
        kb_pulse(d[7:0]);
        if (!kb_full) begin
          kb_full = 1;
          kb_char = d[7:0];
        end
      end
      disp_busy = 1'($urandom);
      case ($urandom_range(0, 5))
        0, 1, 5: a = 16'($urandom_range(0, 63));
        2: a = 16'(64 + $urandom_range(0, 10));
        3: a = 16'hFE00 + 16'(2 * $urandom_range(0, 3));
        default: a = 16'($urandom);
      endcase
      w = 1'($urandom);
      d = 16'($urandom);
      exp = a == 16'hFE00 ? {kb_full, 15'b0} : a == 16'hFE02 ? {8'h00, kb_char} :
            a == 16'hFE04 ? (disp_busy ? 16'h0000 : 16'h8000) :
            a == 16'hFE06 ? 16'h0000 : a < 64 ? mem_m[a[5:0]] : 16'h0000;
      access(w, a, d, rd, lat);
      chk($sformatf("rnd%0d_lat a=%0h", i, a), 32'(lat), 32'(m_lat(a)));
      if (!w) chk($sformatf("rnd%0d_data a=%0h", i, a), {16'b0, rd}, {16'b0, exp});
      if (w && a < 64) mem_m[a[5:0]] = d;
      if (!w && a == 16'hFE02) kb_full = 0;
      if (w && a == 16'hFE06) begin
        m_disp_cnt++;
        m_last_disp = d[7:0];
      end
    end
    disp_busy = 0;
    repeat (2) @(negedge clk);
    chk("rnd_disp_cnt", 32'(disp_cnt), 32'(m_disp_cnt));
    chk("rnd_disp_last", {24'b0, last_disp}, {24'b0, m_last_disp});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
